counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Time-slot arbiter and sequencer for the shared 4-bit up-counter (`counter`, ports q/clk/clr). Up to NREQ requesters each ask for an interval of L clock cycles. The block grants the counter to one requester at a time in round-robin order, clears it at the start of each slot, watches its count, and ends the slot with a done pulse. It sits between the requester blocks and the single counter instance; nothing else drives the counter's clr.

## Interface
- NREQ, 4, number of requesters (legal 2..8)
- clk  in  1  system clock; all state changes on its rising edge
- clr  in  1  reset, synchronous, active-high; dominates every other input
- req  in  NREQ  request per requester; held high until done or abort
- len  in  4*NREQ  requested length per requester; len[4i+3:4i] belongs to requester i; sampled only at grant
- cnt_q  in  4  q output of the shared counter
- cnt_clr  out  1  drives the counter's clr
- gnt  out  NREQ  one-hot grant, or all zero
- done  out  NREQ  one-hot, one-cycle completion pulse
- busy  out  1  high whenever state is not IDLE

## Operation
- Counter contract: when cnt_clr is high at a rising edge, q becomes 0; otherwise q becomes q+1 mod 16.
- Slot length: L = len, except len=0, which gives L=1. Maximum L is 15.
- The FSM has four states:
  - IDLE: cnt_clr=1.
    - If any req is high, pick the first requester above ptr (the last granted index), searching circularly.
    - Latch its index and L, set gnt to its one-hot, and go to LOAD.
    - If no req is high, stay in IDLE.
  - LOAD: cnt_clr=1, gnt held. Unconditionally go to RUN.
  - RUN: cnt_clr=0, gnt held.
    - When cnt_q == L-1 is sampled, go to DONE: gnt<=0, done<=one-hot(idx), ptr<=idx.
  - DONE: cnt_clr=1, done high for this cycle only. Unconditionally go to IDLE.
- Abort: if req[idx] is low in LOAD or RUN, go directly to IDLE. gnt<=0, ptr<=idx, and no done pulse.
- Outside IDLE, req changes from non-granted requesters are ignored. len is ignored except at the grant edge.
- Because L ≤ 15, cnt_q never wraps within a slot. The compare is an exact 4-bit equality.
- All outputs are registered; there is no combinational path from req to gnt.

## Timing
- Reset values: state=IDLE, gnt=0, done=0, busy=0, cnt_clr=1, ptr=NREQ-1, so requester 0 wins the first arbitration.
- clr high at an edge forces the reset values on the next cycle, including mid-slot. An interrupted slot produces no done.
- Grant latency: req sampled high in IDLE at edge E0 → gnt high from E0.
- Slot sequence:
  - gnt stays high for L+1 cycles: 1 LOAD cycle plus L RUN cycles.
  - The counter shows 0..L-1 during RUN.
  - done is high in the cycle immediately after the last gnt cycle.
- Turnaround: each slot occupies L+3 cycles (LOAD, RUN×L, DONE, IDLE). Back-to-back grants are separated by 2 gnt-low cycles.
- Requesters must drop req in the DONE cycle. A req still high after DONE is treated as a new request and is arbitrated normally.
- Abort: the edge that samples req[idx]=0 clears gnt and sets state=IDLE. The next grant comes no earlier than one cycle later.

## Test plan
- Reset: clr high for 2 cycles with all req high → gnt=0, done=0, busy=0, cnt_clr=1. After release, the first gnt is 4'b0001.
- Single slot: req[0]=1, len0=3 → gnt=0001 for 4 cycles, with cnt_clr=1 then 0,0,0. cnt_q is 0,1,2 during RUN. done=0001 for exactly 1 cycle, then busy=0.
- Round-robin: all req high, all len=1 → grant order 0,1,2,3,0. Each gnt lasts 2 cycles, and a new gnt starts every 4 cycles.
- Length bounds:
  - len=0 → same waveform as len=1.
  - len=15 → gnt high for 16 cycles, cnt_q reaches 14, done fires, and cnt_q never wraps.
- Abort: req[1] granted with len=10, req[1] dropped during the 3rd RUN cycle → gnt=0 next cycle, no done. With req[1] and req[2] then high, req[2] is granted first.
- Mid-slot reset: clr pulsed during RUN → next cycle gnt=0, done=0, cnt_clr=1, busy=0. The next arbitration grants the lowest-index active requester.

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin time-slot arbiter that owns the clear of one shared 4-bit up-counter.
// Each grant clears the counter, runs it for L cycles, then emits a one-cycle done.
module counter_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [4*NREQ-1:0]   len_i,
    input  logic [3:0]          cnt_q_i,
    output logic                cnt_clr_o,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     done_o,
    output logic                busy_o
);

    localparam int unsigned     IdxW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);
    localparam logic [IdxW-1:0] PtrRst  = IdxW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [3:0]        lm1_q, lm1_d;
    logic              cnt_clr_q, cnt_clr_d;
    logic              busy_q, busy_d;

    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cand;
    logic [3:0]        pick_len;
    logic [3:0]        pick_lm1;

    // Scan from the farthest candidate inward so the nearest one after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = IdxW'((32'(ptr_q) + k) % NREQ);
            if (req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_len = len_i[4*pick_idx +: 4];
        pick_lm1 = (pick_len == 4'd0) ? 4'd0 : pick_len - 4'd1;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        lm1_d   = lm1_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StLoad;
                    idx_d   = pick_idx;
                    lm1_d   = pick_lm1;
                    gnt_d   = OneHot0 << pick_idx;
                end
            end
            StLoad: begin
                if (!req_i[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort takes priority over a completion on the same edge.
                if (!req_i[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                end else if (cnt_q_i == lm1_q) begin
                    state_d = StDone;
                    gnt_d   = '0;
                    done_d  = OneHot0 << idx_q;
                    ptr_d   = idx_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
        cnt_clr_d = (state_d != StRun);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            done_q    <= '0;
            idx_q     <= '0;
            ptr_q     <= PtrRst;
            lm1_q     <= '0;
            cnt_clr_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            lm1_q     <= lm1_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign cnt_clr_o = cnt_clr_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural model of the shared counter.
module tb_counter_arbiter;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  cnt_q;
    logic        cnt_clr;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    counter_arbiter #(.NREQ(4)) dut (
        .clk_i     (clk),
        .clr_i     (clr),
        .req_i     (req),
        .len_i     (len),
        .cnt_q_i   (cnt_q),
        .cnt_clr_o (cnt_clr),
        .gnt_o     (gnt),
        .done_o    (done),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared counter: clear dominates, otherwise increment mod 16.
    always_ff @(posedge clk) cnt_q <= cnt_clr ? 4'd0 : cnt_q + 4'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        req = 4'b0000;
        tick();
        clr = 1'b0;
    endtask

    // Entered right after the grant edge (state LOAD); returns one cycle into IDLE.
    task automatic slot(input logic [3:0] g, input int l, input bit drop);
        check("load gnt", 32'(gnt), 32'(g));
        check("load cnt_clr", 32'(cnt_clr), 32'd1);
        check("load busy", 32'(busy), 32'd1);
        for (int i = 0; i < l; i++) begin
            tick();
            check("run gnt", 32'(gnt), 32'(g));
            check("run cnt_clr", 32'(cnt_clr), 32'd0);
            check("run cnt_q", 32'(cnt_q), 32'(i));
            check("run done", 32'(done), 32'd0);
        end
        tick();
        check("done gnt", 32'(gnt), 32'd0);
        check("done pulse", 32'(done), 32'(g));
        check("done cnt_clr", 32'(cnt_clr), 32'd1);
        if (drop) req = req & ~g;
        tick();
        check("idle done", 32'(done), 32'd0);
        check("idle gnt", 32'(gnt), 32'd0);
        check("idle busy", 32'(busy), 32'd0);
    endtask

    logic [3:0] rr_order [5];

    initial begin
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset held two cycles with every requester asking.
        clr = 1'b1;
        req = 4'b1111;
        len = 16'h1111;
        tick();
        tick();
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst cnt_clr", 32'(cnt_clr), 32'd1);
        clr = 1'b0;
        tick();
        check("first gnt", 32'(gnt), 32'h1);

        // Single slot, L=3.
        do_reset();
        req = 4'b0001;
        len = 16'h0003;
        tick();
        slot(4'b0001, 3, 1'b1);
        tick();
        check("single stays idle", 32'(gnt), 32'd0);

        // Round robin, L=1, requests held throughout.
        do_reset();
        req = 4'b1111;
        len = 16'h1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            slot(rr_order[s], 1, 1'b0);
            tick();
        end

        // len=0 behaves as L=1.
        do_reset();
        req = 4'b0001;
        len = 16'h0000;
        tick();
        slot(4'b0001, 1, 1'b1);

        // len=15 on requester 1.
        do_reset();
        req = 4'b0010;
        len = 16'h00F0;
        tick();
        slot(4'b0010, 15, 1'b1);

        // Abort requester 1 during its third RUN cycle.
        do_reset();
        req = 4'b0010;
        len = 16'h00A0;
        tick();
        check("abort load gnt", 32'(gnt), 32'h2);
        tick();
        tick();
        tick();
        check("abort run3 cnt_q", 32'(cnt_q), 32'd2);
        req = 4'b0000;
        tick();
        check("abort gnt", 32'(gnt), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort cnt_clr", 32'(cnt_clr), 32'd1);
        req = 4'b0110;
        tick();
        check("post-abort gnt", 32'(gnt), 32'h4);
        check("post-abort done", 32'(done), 32'd0);

        // Reset pulsed mid-slot.
        do_reset();
        req = 4'b0001;
        len = 16'h0005;
        tick();
        tick();
        tick();
        check("midrst run cnt_clr", 32'(cnt_clr), 32'd0);
        clr = 1'b1;
        req = 4'b1010;
        tick();
        check("midrst gnt", 32'(gnt), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst cnt_clr", 32'(cnt_clr), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        clr = 1'b0;
        tick();
        check("midrst regrant", 32'(gnt), 32'h2);
        check("midrst no done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
